// File: rtl/reg_file_param_pkg.sv
// Shared definitions for the reg_file_param register file: default sizes,
// stack-pointer adjust encoding and the exchange state machine states.
package reg_file_param_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_REGS  = 8;
  localparam int DEF_BYTE_REGS = 4;
  localparam int DEF_SP_IDX    = 4;

  localparam logic [1:0] SP_NONE  = 2'b00;
  localparam logic [1:0] SP_INC   = 2'b01;
  localparam logic [1:0] SP_DEC   = 2'b10;
  localparam logic [1:0] SP_NONE2 = 2'b11;

  typedef enum logic [1:0] {
    XCHG_IDLE  = 2'd0,
    XCHG_LATCH = 2'd1,
    XCHG_WR_A  = 2'd2,
    XCHG_WR_B  = 2'd3
  } xchg_state_t;

endpackage

// File: rtl/reg_file_xchg_fsm.sv
// Register exchange sequencer: accepts a swap request, latches both operands,
// then takes over the register file write port for two cycles.
module reg_file_xchg_fsm
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xchg_req,
  input  logic              wr_en,
  input  logic [AW-1:0]     xchg_a,
  input  logic [AW-1:0]     xchg_b,
  input  logic [DATA_W-1:0] val_a,
  input  logic [DATA_W-1:0] val_b,
  output logic [AW-1:0]     sel_a,
  output logic [AW-1:0]     sel_b,
  output logic              ov_en,
  output logic [AW-1:0]     ov_addr,
  output logic [DATA_W-1:0] ov_data,
  output logic              xchg_ack,
  output logic              xchg_busy,
  output logic              xchg_done
);

  xchg_state_t       state;
  xchg_state_t       next_state;
  logic              accept;
  logic [AW-1:0]     a_q;
  logic [AW-1:0]     b_q;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;

  // A pending user write always wins over a new exchange request.
  assign accept = (state == XCHG_IDLE) && xchg_req && !wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= XCHG_IDLE;
      xchg_ack  <= 1'b0;
      xchg_done <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= next_state;
      xchg_ack  <= accept;
      xchg_done <= (state == XCHG_WR_B);
      if (accept) begin
        a_q <= xchg_a;
        b_q <= xchg_b;
      end
    end
  end

  // Operand snapshot; never observed outside WR_A/WR_B, so left unreset.
  always_ff @(posedge clk) begin
    if (state == XCHG_LATCH) begin
      lat_a <= val_a;
      lat_b <= val_b;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      XCHG_IDLE:  if (accept) next_state = XCHG_LATCH;
      XCHG_LATCH: next_state = XCHG_WR_A;
      XCHG_WR_A:  next_state = XCHG_WR_B;
      XCHG_WR_B:  next_state = XCHG_IDLE;
      default:    next_state = XCHG_IDLE;
    endcase
  end

  always_comb begin
    xchg_busy = (state != XCHG_IDLE);
    ov_en     = 1'b0;
    ov_addr   = a_q;
    ov_data   = lat_b;
    case (state)
      XCHG_WR_A: ov_en = 1'b1;
      XCHG_WR_B: begin
        ov_en   = 1'b1;
        ov_addr = b_q;
        ov_data = lat_a;
      end
      default: ;
    endcase
  end

  assign sel_a = a_q;
  assign sel_b = b_q;

endmodule

// File: rtl/reg_file_param.sv
// Parameterised register file with byte-writable low registers, a stack
// pointer with +/-2 adjust and a two-register exchange sequencer.
// Optional same-cycle write-to-read bypass: define REG_FILE_BYPASS_EN.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int BYTE_REGS = DEF_BYTE_REGS,
  parameter int SP_IDX    = DEF_SP_IDX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_size,
  input  logic                        wr_hi,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr2,
  output logic [DATA_W-1:0]           rd_data1,
  output logic [DATA_W-1:0]           rd_data2,
  input  logic [1:0]                  sp_adj,
  input  logic                        xchg_req,
  input  logic [$clog2(NUM_REGS)-1:0] xchg_a,
  input  logic [$clog2(NUM_REGS)-1:0] xchg_b,
  output logic                        xchg_ack,
  output logic                        xchg_busy,
  output logic                        xchg_done
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int HW = DATA_W / 2;
  localparam logic [AW-1:0] SP_A     = AW'(SP_IDX);
  localparam logic [AW:0]   BYTE_LIM = (AW + 1)'(BYTE_REGS);

  function automatic logic [DATA_W-1:0] merge_write(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] data,
    input logic              full,
    input logic              hi
  );
    if (full)    return data;
    else if (hi) return {data[HW-1:0], old_val[HW-1:0]};
    else         return {old_val[DATA_W-1:HW], data[HW-1:0]};
  endfunction

  function automatic logic [DATA_W-1:0] sp_step(
    input logic [DATA_W-1:0] cur,
    input logic [1:0]        adj
  );
    case (adj)
      SP_INC:  return cur + DATA_W'(2);
      SP_DEC:  return cur - DATA_W'(2);
      default: return cur;
    endcase
  endfunction

  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [DATA_W-1:0] next_regs [NUM_REGS];

  logic              ov_en;
  logic [AW-1:0]     ov_addr;
  logic [DATA_W-1:0] ov_data;
  logic [AW-1:0]     sel_a;
  logic [AW-1:0]     sel_b;

  logic              user_we;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic              wfull;
  logic              wp_hit;
  logic [DATA_W-1:0] wp_val;
  logic              sp_go;

  reg_file_xchg_fsm #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_xchg (
    .clk       (clk),
    .reset     (reset),
    .xchg_req  (xchg_req),
    .wr_en     (wr_en),
    .xchg_a    (xchg_a),
    .xchg_b    (xchg_b),
    .val_a     (regs[sel_a]),
    .val_b     (regs[sel_b]),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ov_en     (ov_en),
    .ov_addr   (ov_addr),
    .ov_data   (ov_data),
    .xchg_ack  (xchg_ack),
    .xchg_busy (xchg_busy),
    .xchg_done (xchg_done)
  );

  // The exchange owns the write port while busy; user writes are dropped.
  assign user_we = wr_en && !xchg_busy;
  assign we      = ov_en || user_we;
  assign waddr   = ov_en ? ov_addr : wr_addr;
  assign wdata   = ov_en ? ov_data : wr_data;
  assign wfull   = ov_en || wr_size;
  assign wp_hit  = we && (wfull || ({1'b0, waddr} < BYTE_LIM));
  assign wp_val  = merge_write(regs[waddr], wdata, wfull, wr_hi);

  // Any write aimed at the stack pointer suppresses the adjust that cycle.
  assign sp_go = !xchg_busy && !(we && (waddr == SP_A));

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      next_regs[i] = regs[i];
      if (i == SP_IDX && sp_go)
        next_regs[i] = sp_step(regs[i], sp_adj);
      if (wp_hit && (waddr == AW'(i)))
        next_regs[i] = wp_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= next_regs[i];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  assign rd_data1 = (wp_hit && (waddr == rd_addr1)) ? wp_val : regs[rd_addr1];
  assign rd_data2 = (wp_hit && (waddr == rd_addr2)) ? wp_val : regs[rd_addr2];
`else
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
`endif

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register width in bits (even, >=8).
REQ-002 The block SHALL have parameter NUM_REGS, default 8, register count (power of two, >=4); AW = log2(NUM_REGS).
REQ-003 The block SHALL have parameter BYTE_REGS, default 4, meaning registers 0..BYTE_REGS-1 accept byte writes.
REQ-004 The block SHALL have parameter SP_IDX, default 4, the index of the stack-pointer register.
REQ-005 The block SHALL have ports: clk in 1, clock; reset in 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have ports: wr_en in 1, write strobe; wr_addr in AW, write target; wr_data in DATA_W, write data; wr_size in 1 (1 full word, 0 byte); wr_hi in 1 (1 upper byte, 0 lower byte).
REQ-007 The block SHALL have ports: rd_addr1/rd_addr2 in AW, read selects; rd_data1/rd_data2 out DATA_W, read data.
REQ-008 The block SHALL have ports: sp_adj in 2 (00 none, 01 SP+2, 10 SP-2, 11 none); xchg_req in 1; xchg_a/xchg_b in AW; xchg_ack out 1; xchg_busy out 1; xchg_done out 1.

Function
REQ-009 Full write: with wr_en=1 and wr_size=1, register wr_addr SHALL take wr_data at the next clk rising edge.
REQ-010 Byte write: with wr_size=0 and wr_addr<BYTE_REGS, only the lower (wr_hi=0) or upper (wr_hi=1) DATA_W/2 bits SHALL take wr_data[DATA_W/2-1:0]; with wr_addr>=BYTE_REGS no register SHALL change.
REQ-011 Reads SHALL be combinational from register state, with zero latency.
REQ-012 sp_adj SHALL update SP by +2 or -2 at the clock edge, modulo 2^DATA_W (0x0000-2 = 0xFFFE; 0xFFFE+2 = 0x0000).
REQ-013 A same-cycle wr_en targeting SP_IDX SHALL override sp_adj.
REQ-014 The XCHG FSM SHALL have states IDLE, LATCH, WR_A, WR_B; xchg_busy SHALL be 1 in every state except IDLE.
REQ-015 IDLE->LATCH SHALL occur when xchg_req=1 and wr_en=0; xchg_ack SHALL pulse for one cycle on acceptance, and xchg_a/xchg_b SHALL be captured at that edge.
REQ-016 If wr_en=1 and xchg_req=1 in IDLE, the write SHALL execute and the exchange SHALL NOT be accepted (no ack); the requester holds xchg_req.
REQ-017 LATCH SHALL capture both register values, WR_A SHALL write the old B value into A, and WR_B SHALL write the old A value into B, then return to IDLE with xchg_done pulsing for one cycle; total exchange is 3 cycles after ack.
REQ-018 xchg_a == xchg_b SHALL still traverse all states, leaving the register unchanged.
REQ-019 While xchg_busy=1, wr_en, sp_adj and xchg_req SHALL be ignored.

Reset
REQ-020 Reset SHALL force every register to 0, the FSM to IDLE, and xchg_ack, xchg_busy and xchg_done to 0, asynchronously and also mid-exchange, with no partial swap completed afterwards.

Configuration
REQ-021 With REG_FILE_BYPASS_EN defined, a read of the register being written in the same cycle (wr_en or WR_A/WR_B) SHALL return the merged post-write value.
REQ-022 With REG_FILE_BYPASS_EN undefined, reads SHALL return the pre-write value.

Structure
REQ-023 A shared package SHALL hold the sp_adj encoding constants, the XCHG state enumeration, and the default parameter values.
REQ-024 A sub-module reg_file_xchg_fsm SHALL contain the exchange state machine and drive the write-port overrides.

Verification
REQ-025 Reset, then full-write 0x1234 to reg 1 -> rd_data1 (rd_addr1=1) reads 0x1234 the next cycle; all other registers read 0.
REQ-026 Reg 0=0x1234, byte write 0xAB with wr_hi=1 -> 0xAB34; byte write to reg 5 -> reg 5 unchanged.
REQ-027 SP=0x0000, sp_adj=10 -> 0xFFFE; sp_adj=01 -> 0x0000; wr_en to SP with 0x0100 plus sp_adj=01 -> 0x0100.
REQ-028 Reg 2=0x1111, reg 3=0x2222, xchg 2<->3 -> ack, busy for 3 cycles, done, then reg 2=0x2222 and reg 3=0x1111; a wr_en during busy has no effect.
REQ-029 Assert reset in WR_A -> all registers 0, FSM IDLE, no done pulse.
REQ-030 Same-cycle write 0x5555 to reg 6 with rd_addr1=6 -> 0x5555 with bypass, old value without bypass.
